// File: rtl/pkg_busca.sv
// rtl/pkg_busca.sv - shared state encoding and default sizes for the fetch unit
package pkg_busca;

    localparam int PROFUNDIDADE_PADRAO  = 2;
    localparam int LARGURA_INSTR_PADRAO = 32;
    localparam int LARGURA_ENDERECO     = 64;

    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        REQUISITANDO = 2'd1,
        DESCARTANDO  = 2'd2
    } estado_t;

endpackage

// File: rtl/fila_instrucoes.sv
// rtl/fila_instrucoes.sv - instruction buffer holding fetched words with their addresses
module fila_instrucoes
    import pkg_busca::*;
#(
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int LARGURA      = LARGURA_INSTR_PADRAO
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [LARGURA-1:0]            push_dado,
    input  logic [LARGURA_ENDERECO-1:0]   push_endereco,
    input  logic                          pop,
    input  logic                          flush,
    output logic [LARGURA-1:0]            cabeca_dado,
    output logic [LARGURA_ENDERECO-1:0]   cabeca_endereco,
    output logic [$clog2(PROFUNDIDADE):0] count
);
    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int CW = PW + 1;

    logic [LARGURA-1:0]          dados     [PROFUNDIDADE];
    logic [LARGURA_ENDERECO-1:0] enderecos [PROFUNDIDADE];
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        vazia;
    logic                        cheia;
    logic                        do_push;
    logic                        do_pop;

    assign vazia   = (count == '0);
    assign cheia   = (count == CW'(PROFUNDIDADE));
    assign do_pop  = pop && !vazia;
    // a full buffer can still take a word when the head leaves on the same edge
    assign do_push = push && (!cheia || do_pop);

    assign cabeca_dado     = dados[rd_ptr];
    assign cabeca_endereco = enderecos[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                dados[i]     <= '0;
                enderecos[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                dados[wr_ptr]     <= push_dado;
                enderecos[wr_ptr] <= push_endereco;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/unidade_busca.sv
// rtl/unidade_busca.sv - instruction fetch unit: one outstanding memory read feeding a small buffer
module unidade_busca
    import pkg_busca::*;
#(
    parameter int PROFUNDIDADE  = PROFUNDIDADE_PADRAO,
    parameter int LARGURA_INSTR = LARGURA_INSTR_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [LARGURA_ENDERECO-1:0] endereco,
    output logic                        avanca_pc,
    output logic                        mem_req,
    output logic [LARGURA_ENDERECO-1:0] mem_endereco,
    input  logic                        mem_ack,
    input  logic [LARGURA_INSTR-1:0]    mem_dado,
    input  logic                        descartar,
    output logic [LARGURA_INSTR-1:0]    instrucao,
    output logic [LARGURA_ENDERECO-1:0] instrucao_endereco,
    output logic                        instrucao_valida,
    input  logic                        instrucao_pronta
);
    localparam int CW = $clog2(PROFUNDIDADE) + 1;

    estado_t                     estado;
    estado_t                     prox_estado;
    logic                        prox_mem_req;
    logic                        prox_avanca_pc;
    logic [LARGURA_ENDERECO-1:0] prox_mem_endereco;
    logic                        push;
    logic [CW-1:0]               count;

    fila_instrucoes #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA      (LARGURA_INSTR)
    ) u_fila (
        .clock           (clock),
        .reset           (reset),
        .push            (push),
        .push_dado       (mem_dado),
        .push_endereco   (mem_endereco),
        .pop             (instrucao_pronta),
        .flush           (descartar),
        .cabeca_dado     (instrucao),
        .cabeca_endereco (instrucao_endereco),
        .count           (count)
    );

    assign instrucao_valida = (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= OCIOSO;
            mem_req      <= 1'b0;
            mem_endereco <= '0;
            avanca_pc    <= 1'b0;
        end else begin
            estado       <= prox_estado;
            mem_req      <= prox_mem_req;
            mem_endereco <= prox_mem_endereco;
            avanca_pc    <= prox_avanca_pc;
        end
    end

    always_comb begin
        prox_estado       = estado;
        prox_mem_req      = mem_req;
        prox_mem_endereco = mem_endereco;
        prox_avanca_pc    = 1'b0;
        push              = 1'b0;
        case (estado)
            OCIOSO: begin
                // while avanca_pc is high the PC still shows the word just fetched
                if (count < CW'(PROFUNDIDADE) && !descartar && !avanca_pc) begin
                    prox_mem_req      = 1'b1;
                    prox_mem_endereco = endereco;
                    prox_estado       = REQUISITANDO;
                end
            end
            REQUISITANDO: begin
                if (mem_ack) begin
                    prox_mem_req = 1'b0;
                    prox_estado  = OCIOSO;
                    if (!descartar) begin
                        push           = 1'b1;
                        prox_avanca_pc = 1'b1;
                    end
                end else if (descartar) begin
                    prox_estado = DESCARTANDO;
                end
            end
            DESCARTANDO: begin
                if (mem_ack) begin
                    prox_mem_req = 1'b0;
                    prox_estado  = OCIOSO;
                end
            end
            default: begin
                prox_mem_req = 1'b0;
                prox_estado  = OCIOSO;
            end
        endcase
    end

endmodule

// File: tb/tb_unidade_busca.sv
// tb/tb_unidade_busca.sv - randomized scoreboard bench for unidade_busca
module tb_unidade_busca;
    localparam int PROF = 2;
    localparam int LW   = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   endereco = '0;
    logic          avanca_pc;
    logic          mem_req;
    logic [63:0]   mem_endereco;
    logic          mem_ack = 1'b0;
    logic [LW-1:0] mem_dado = '0;
    logic          descartar = 1'b0;
    logic [LW-1:0] instrucao;
    logic [63:0]   instrucao_endereco;
    logic          instrucao_valida;
    logic          instrucao_pronta = 1'b0;

    unidade_busca #(.PROFUNDIDADE(PROF), .LARGURA_INSTR(LW)) dut (
        .clock              (clock),
        .reset              (reset),
        .endereco           (endereco),
        .avanca_pc          (avanca_pc),
        .mem_req            (mem_req),
        .mem_endereco       (mem_endereco),
        .mem_ack            (mem_ack),
        .mem_dado           (mem_dado),
        .descartar          (descartar),
        .instrucao          (instrucao),
        .instrucao_endereco (instrucao_endereco),
        .instrucao_valida   (instrucao_valida),
        .instrucao_pronta   (instrucao_pronta)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]   addr;
        logic [LW-1:0] dado;
    } ent_t;

    ent_t        exp_q[$];
    logic [63:0] popped[$];
    int          checks = 0;
    int          errors = 0;
    bit          checking = 1'b0;

    logic [63:0] pc = '0;
    logic [63:0] br_target = '0;
    logic [63:0] req_addr = '0;
    bit          outstanding = 1'b0;
    bit          poisoned = 1'b0;
    bit          exp_avanca = 1'b0;
    bit          just_req = 1'b0;
    int          wait_cnt = 0;
    int          p_pronta = 100;
    int          p_desc = 0;
    int          lat_min = 2;
    int          lat_max = 2;

    task automatic chk(input bit ok, input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic drive_desc();
        descartar = 1'b1;
        br_target = {$urandom, $urandom};
    endtask

    // one clock: apply the effect of last cycle's inputs to the model, then drive new inputs
    task automatic step();
        logic          p_ack;
        logic          p_desc_l;
        logic [LW-1:0] p_dado;
        logic [63:0]   p_end;
        bit            prev_av;
        @(posedge clock);
        #2;
        p_ack    = mem_ack;
        p_desc_l = descartar;
        p_dado   = mem_dado;
        p_end    = endereco;
        prev_av  = exp_avanca;
        just_req = 1'b0;

        exp_avanca = 1'b0;
        if (p_ack && outstanding) begin
            if (!poisoned && !p_desc_l) begin
                exp_q.push_back('{req_addr, p_dado});
                exp_avanca = 1'b1;
            end
            outstanding = 1'b0;
        end else if (p_desc_l && outstanding) begin
            poisoned = 1'b1;
        end
        if (p_desc_l) begin
            exp_q.delete();
            pc = br_target;
        end else if (prev_av) begin
            pc = pc + 64'd1;
        end

        if (mem_req && !outstanding) begin
            outstanding = 1'b1;
            poisoned    = 1'b0;
            just_req    = 1'b1;
            req_addr    = p_end;
            chk(mem_endereco == p_end, "req_addr", mem_endereco, p_end);
            wait_cnt = $urandom_range(lat_max, lat_min);
        end

        mem_ack   = 1'b0;
        descartar = 1'b0;
        mem_dado  = $urandom;
        if (outstanding) begin
            if (wait_cnt == 0) mem_ack = 1'b1;
            else wait_cnt--;
        end
        instrucao_pronta = ($urandom_range(99, 0) < p_pronta);
        if ($urandom_range(99, 0) < p_desc) drive_desc();
        endereco = pc;
    endtask

    task automatic do_reset(input logic [63:0] pc0);
        checking         = 1'b0;
        reset            = 1'b1;
        mem_ack          = 1'b0;
        descartar        = 1'b0;
        instrucao_pronta = 1'b0;
        @(posedge clock);
        #2;
        chk(mem_req == 1'b0, "rst_mem_req", mem_req, 0);
        chk(avanca_pc == 1'b0, "rst_avanca_pc", avanca_pc, 0);
        chk(instrucao_valida == 1'b0, "rst_valida", instrucao_valida, 0);
        chk(mem_endereco == 64'd0, "rst_mem_endereco", mem_endereco, 0);
        chk(instrucao == '0, "rst_instrucao", 64'(instrucao), 0);
        chk(instrucao_endereco == 64'd0, "rst_instr_end", instrucao_endereco, 0);
        reset = 1'b0;
        exp_q.delete();
        popped.delete();
        outstanding = 1'b0;
        poisoned    = 1'b0;
        exp_avanca  = 1'b0;
        wait_cnt    = 0;
        pc          = pc0;
        endereco    = pc0;
        checking    = 1'b1;
    endtask

    always @(negedge clock) begin
        if (checking) begin
            chk(avanca_pc == exp_avanca, "avanca_pc", avanca_pc, exp_avanca);
            chk(instrucao_valida == (exp_q.size() != 0), "instrucao_valida", instrucao_valida, exp_q.size() != 0);
            if (exp_q.size() == PROF) chk(mem_req == 1'b0, "full_no_req", mem_req, 0);
            if (outstanding) chk(mem_req && (mem_endereco == req_addr), "req_hold", mem_endereco, req_addr);
            if (instrucao_valida && exp_q.size() != 0) begin
                chk(instrucao_endereco == exp_q[0].addr, "head_addr", instrucao_endereco, exp_q[0].addr);
                chk(instrucao == exp_q[0].dado, "head_data", 64'(instrucao), 64'(exp_q[0].dado));
                if (instrucao_pronta) begin
                    popped.push_back(instrucao_endereco);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [63:0] second_addr;

        // in-order stream from address 0
        do_reset(64'd0);
        p_pronta = 100; p_desc = 0; lat_min = 2; lat_max = 2;
        k = 0;
        while (popped.size() < 3 && k < 100) begin step(); k++; end
        chk(popped.size() >= 3, "seq_timeout", popped.size(), 3);
        if (popped.size() >= 3) begin
            chk(popped[0] == 64'd0, "seq_0", popped[0], 0);
            chk(popped[1] == 64'd1, "seq_1", popped[1], 1);
            chk(popped[2] == 64'd2, "seq_2", popped[2], 2);
        end

        // fill without a consumer, then release one entry
        do_reset(64'h10);
        p_pronta = 0;
        k = 0;
        while (exp_q.size() < 2 && k < 100) begin step(); k++; end
        chk(exp_q.size() == 2, "fill_timeout", exp_q.size(), 2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk(mem_req == 1'b0, "fill_no_req", mem_req, 0);
        end
        chk(instrucao_endereco == 64'h10, "fill_head", instrucao_endereco, 64'h10);
        step();
        instrucao_pronta = 1'b1;
        k = 0;
        do begin step(); k++; end while (!just_req && k < 20);
        chk(just_req, "refill_timeout", just_req, 1);
        chk(mem_endereco == 64'h12, "refill_addr", mem_endereco, 64'h12);

        // flush during an outstanding read drops its data
        p_pronta = 100; lat_min = 3; lat_max = 3;
        k = 0;
        do begin step(); k++; end while (!just_req && k < 50);
        chk(just_req, "flush_req_timeout", just_req, 1);
        drive_desc();
        k = 0;
        do begin step(); k++; end while (!mem_ack && k < 10);
        chk(mem_ack, "flush_ack_timeout", mem_ack, 1);
        mem_dado = 32'hDEADBEEF;
        step();
        chk(avanca_pc == 1'b0, "flush_no_avanca", avanca_pc, 0);
        chk(instrucao_valida == 1'b0, "flush_empty", instrucao_valida, 0);

        // flush coinciding with ack and pop while one entry is buffered
        p_pronta = 0; lat_min = 2; lat_max = 2;
        k = 0;
        do begin step(); k++; end while (!(exp_q.size() == 1 && mem_ack) && k < 100);
        chk(exp_q.size() == 1 && mem_ack, "coinc_timeout", exp_q.size(), 1);
        drive_desc();
        instrucao_pronta = 1'b1;
        step();
        chk(instrucao_valida == 1'b0, "coinc_empty", instrucao_valida, 0);
        chk(avanca_pc == 1'b0, "coinc_no_avanca", avanca_pc, 0);

        // push and pop on the same edge keep order
        k = 0;
        do begin step(); k++; end while (!(exp_q.size() == 1 && mem_ack) && k < 100);
        chk(exp_q.size() == 1 && mem_ack, "pushpop_timeout", exp_q.size(), 1);
        second_addr = req_addr;
        instrucao_pronta = 1'b1;
        step();
        chk(instrucao_valida == 1'b1, "pushpop_valid", instrucao_valida, 1);
        chk(instrucao_endereco == second_addr, "pushpop_order", instrucao_endereco, second_addr);

        // reset in the middle of a read; the late ack must be ignored
        p_pronta = 100; lat_min = 3; lat_max = 3;
        k = 0;
        do begin step(); k++; end while (!just_req && k < 50);
        chk(just_req && mem_req, "rstmid_timeout", mem_req, 1);
        do_reset(64'h40);
        mem_ack  = 1'b1;
        mem_dado = 32'hCAFEF00D;
        step();
        chk(instrucao_valida == 1'b0, "rstmid_no_push", instrucao_valida, 0);
        chk(avanca_pc == 1'b0, "rstmid_no_avanca", avanca_pc, 0);
        step();
        chk(instrucao_valida == 1'b0, "rstmid_no_push2", instrucao_valida, 0);

        // random traffic
        p_pronta = 60; p_desc = 5; lat_min = 1; lat_max = 5;
        repeat (4000) step();

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
